// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state encoding and burst lengths for sdram_req_arbiter.
package sdram_arb_pkg;
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, GUARD, WR_REQ, WR_DATA} arb_state_e;
    localparam logic [8:0] RD_BURST_LEN = 9'd8;
    localparam logic [8:0] WR_BURST_LEN = 9'd1;
endpackage

// File: rtl/sdram_req_arbiter.sv
// sdram_req_arbiter: grants video burst reads (priority) or single FTDI writes onto one SDRAM app port.
// Define ARB_WR_STARVE_GUARD_EN to force a pending write through after MAX_RD_RUN read grants.
module sdram_req_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int AW = 25,
    parameter int DW = 16,
    parameter int GUARD_CYC = 2,
    parameter int MAX_RD_RUN = 8
) (
    input  logic          mem_clk,
    input  logic          reset,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_ack,
    output logic          rd_done,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    output logic          wr_done,
    output logic          app_req,
    output logic [AW-1:0] app_req_addr,
    output logic [8:0]    app_req_len,
    output logic          app_req_wr_n,
    output logic [DW-1:0] app_wr_data,
    input  logic          app_req_ack,
    input  logic          app_wr_next_req,
    input  logic          app_rd_valid,
    input  logic          app_last_rd,
    output logic          busy
);
    localparam int GW = $clog2(GUARD_CYC + 2);

    arb_state_e    state_q, state_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic          app_req_q, app_req_d, wr_n_q, wr_n_d;
    logic [8:0]    len_q, len_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          rd_ack_q, rd_ack_d, rd_done_q, rd_done_d;
    logic          wr_ack_q, wr_ack_d, wr_done_q, wr_done_d;
    logic          gnt_rd, gnt_wr, expired, starve;

`ifdef ARB_WR_STARVE_GUARD_EN
    localparam int RW = $clog2(MAX_RD_RUN + 1);
    logic [RW-1:0] run_q, run_d;
    logic          run_sat;
    assign run_sat = run_q == RW'(MAX_RD_RUN);
    assign starve  = wr_req && run_sat;
    always_comb run_d = wr_ack_d ? '0 : (gnt_rd && wr_req && !run_sat) ? run_q + RW'(1) : run_q;
    always_ff @(posedge mem_clk) run_q <= reset ? '0 : run_d;
`else
    localparam int unused_max_rd_run = MAX_RD_RUN;
    assign starve = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        gcnt_d    = gcnt_q;
        app_req_d = app_req_q;
        wr_n_d    = wr_n_q;
        len_d     = len_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_ack_d  = 1'b0;
        rd_done_d = 1'b0;
        wr_ack_d  = 1'b0;
        wr_done_d = 1'b0;
        gnt_rd    = 1'b0;
        gnt_wr    = 1'b0;
        expired   = gcnt_q == GW'(GUARD_CYC);
        case (state_q)
            IDLE: begin
                gnt_rd = rd_req && !starve;
                gnt_wr = wr_req && !gnt_rd;
            end
            RD_REQ: if (app_req_ack) begin
                rd_ack_d  = 1'b1;
                app_req_d = 1'b0;
                state_d   = RD_DATA;
            end
            RD_DATA: if (app_rd_valid && app_last_rd) begin
                rd_done_d = 1'b1;
                gcnt_d    = '0;
                state_d   = GUARD;
            end
            GUARD: begin
                // reads may cut the guard short; writes must wait out the turnaround
                gnt_rd = rd_req && !starve;
                gnt_wr = !gnt_rd && expired && wr_req;
                if (!gnt_rd && !gnt_wr) begin
                    state_d = expired ? IDLE : GUARD;
                    gcnt_d  = expired ? gcnt_q : gcnt_q + GW'(1);
                end
            end
            WR_REQ: if (app_req_ack) begin
                wr_ack_d  = 1'b1;
                wr_done_d = app_wr_next_req;
                app_req_d = 1'b0;
                state_d   = app_wr_next_req ? IDLE : WR_DATA;
            end
            WR_DATA: if (app_wr_next_req) begin
                wr_done_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (gnt_rd) begin
            state_d   = RD_REQ;
            app_req_d = 1'b1;
            wr_n_d    = 1'b1;
            len_d     = RD_BURST_LEN;
            addr_d    = rd_addr;
        end
        if (gnt_wr) begin
            state_d   = WR_REQ;
            app_req_d = 1'b1;
            wr_n_d    = 1'b0;
            len_d     = WR_BURST_LEN;
            addr_d    = wr_addr;
            wdata_d   = wr_data;
        end
    end

    always_ff @(posedge mem_clk) begin
        if (reset) begin
            state_q   <= IDLE;
            gcnt_q    <= '0;
            app_req_q <= 1'b0;
            wr_n_q    <= 1'b1;
            len_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_ack_q  <= 1'b0;
            rd_done_q <= 1'b0;
            wr_ack_q  <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gcnt_q    <= gcnt_d;
            app_req_q <= app_req_d;
            wr_n_q    <= wr_n_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_ack_q  <= rd_ack_d;
            rd_done_q <= rd_done_d;
            wr_ack_q  <= wr_ack_d;
            wr_done_q <= wr_done_d;
        end
    end

    assign app_req      = app_req_q;
    assign app_req_wr_n = wr_n_q;
    assign app_req_len  = len_q;
    assign app_req_addr = addr_q;
    assign app_wr_data  = wdata_q;
    assign rd_ack       = rd_ack_q;
    assign rd_done      = rd_done_q;
    assign wr_ack       = wr_ack_q;
    assign wr_done      = wr_done_q;
    assign busy         = state_q != IDLE;
endmodule

// File: tb/tb_sdram_req_arbiter.sv
// tb_sdram_req_arbiter: directed stimulus with a cycle-stamped event scoreboard for sdram_req_arbiter.
module tb_sdram_req_arbiter;
    localparam int AW = 25;
    localparam int DW = 16;
    localparam int K_REQ = 0, K_RDACK = 1, K_RDDONE = 2, K_WRACK = 3, K_WRDONE = 4;
`ifdef ARB_WR_STARVE_GUARD_EN
    localparam int NRD = 8;
`else
    localparam int NRD = 9;
`endif

    typedef struct {
        int            kind;
        int            cyc;
        logic [AW-1:0] addr;
        logic [8:0]    len;
        logic          wr_n;
        logic [DW-1:0] data;
    } ev_t;

    logic          mem_clk = 1'b0;
    logic          reset = 1'b1;
    logic          rd_req = 1'b0, wr_req = 1'b0;
    logic [AW-1:0] rd_addr = '0, wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          app_req_ack = 1'b0, app_wr_next_req = 1'b0, app_rd_valid = 1'b0, app_last_rd = 1'b0;
    logic          rd_ack, rd_done, wr_ack, wr_done, app_req, app_req_wr_n, busy;
    logic [AW-1:0] app_req_addr;
    logic [8:0]    app_req_len;
    logic [DW-1:0] app_wr_data;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];
    logic req_prev = 1'b0;

    sdram_req_arbiter #(.AW(AW), .DW(DW), .GUARD_CYC(2), .MAX_RD_RUN(8)) dut (
        .mem_clk(mem_clk), .reset(reset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_done(rd_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .wr_done(wr_done),
        .app_req(app_req), .app_req_addr(app_req_addr), .app_req_len(app_req_len),
        .app_req_wr_n(app_req_wr_n), .app_wr_data(app_wr_data),
        .app_req_ack(app_req_ack), .app_wr_next_req(app_wr_next_req),
        .app_rd_valid(app_rd_valid), .app_last_rd(app_last_rd), .busy(busy)
    );

    always #5 mem_clk = ~mem_clk;
    always @(posedge mem_clk) cyc <= cyc + 1;

    task automatic observe(input int k);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, required no event", k, cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != k || e.cyc != cyc ||
            (k == K_REQ && (app_req_addr != e.addr || app_req_len != e.len || app_req_wr_n != e.wr_n ||
                            (!e.wr_n && app_wr_data != e.data)))) begin
            errors++;
            $display("FAIL event_kind%0d: got kind %0d cyc %0d addr %h len %0d wr_n %b data %h, required kind %0d cyc %0d addr %h len %0d wr_n %b data %h",
                     e.kind, k, cyc, app_req_addr, app_req_len, app_req_wr_n, app_wr_data,
                     e.kind, e.cyc, e.addr, e.len, e.wr_n, e.data);
        end
    endtask

    always @(negedge mem_clk) begin
        if (app_req && !req_prev) observe(K_REQ);
        if (rd_ack) observe(K_RDACK);
        if (rd_done) observe(K_RDDONE);
        if (wr_ack) observe(K_WRACK);
        if (wr_done) observe(K_WRDONE);
        req_prev = app_req;
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge mem_clk);
    endtask

    task automatic push(input int k, input int c, input logic [AW-1:0] a = '0, input logic [8:0] l = '0,
                        input logic wn = 1'b1, input logic [DW-1:0] d = '0);
        ev_t e;
        e.kind = k; e.cyc = c; e.addr = a; e.len = l; e.wr_n = wn; e.data = d;
        exp_q.push_back(e);
    endtask

    // called at the negedge where a read app_req is first visible; returns on the GUARD entry cycle
    task automatic serve_read(input bit keep);
        int r;
        r = cyc;
        push(K_RDACK, r + 1);
        push(K_RDDONE, r + 9);
        app_req_ack = 1'b1;
        step();
        app_req_ack = 1'b0;
        if (!keep) rd_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            app_rd_valid = 1'b1;
            app_last_rd = (i == 7);
            step();
        end
        app_rd_valid = 1'b0;
        app_last_rd = 1'b0;
    endtask

    task automatic serve_write(input bit same);
        int w;
        w = cyc;
        push(K_WRACK, w + 1);
        app_req_ack = 1'b1;
        if (same) begin
            app_wr_next_req = 1'b1;
            push(K_WRDONE, w + 1);
            step();
            app_req_ack = 1'b0;
            app_wr_next_req = 1'b0;
            wr_req = 1'b0;
        end else begin
            step();
            app_req_ack = 1'b0;
            wr_req = 1'b0;
            push(K_WRDONE, w + 3);
            step();
            app_wr_next_req = 1'b1;
            step();
            app_wr_next_req = 1'b0;
        end
    endtask

    initial begin
        step(3);
        chk("rst_app_req", app_req, 0);
        chk("rst_wr_n", app_req_wr_n, 1);
        chk("rst_len", app_req_len, 0);
        chk("rst_addr", app_req_addr, 0);
        chk("rst_wdata", app_wr_data, 0);
        chk("rst_pulses", {rd_ack, rd_done, wr_ack, wr_done}, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        step();

        // single read
        rd_addr = 25'h0001000;
        rd_req = 1'b1;
        push(K_REQ, cyc + 1, 25'h0001000, 9'd8, 1'b1);
        step();
        serve_read(1'b0);
        chk("rd_busy_guard0", busy, 1);
        step(2);
        chk("rd_busy_guard2", busy, 1);
        step();
        chk("rd_busy_idle", busy, 0);

        // single write
        wr_addr = 25'h0000040;
        wr_data = 16'hBEEF;
        wr_req = 1'b1;
        push(K_REQ, cyc + 1, 25'h0000040, 9'd1, 1'b0, 16'hBEEF);
        step();
        serve_write(1'b0);
        chk("wr_busy_idle", busy, 0);
        chk("wr_data_held", app_wr_data, 16'hBEEF);

        // simultaneous requests: read first, write after the guard
        rd_addr = 25'h0002000;
        wr_addr = 25'h0000080;
        wr_data = 16'h1234;
        rd_req = 1'b1;
        wr_req = 1'b1;
        push(K_REQ, cyc + 1, 25'h0002000, 9'd8, 1'b1);
        step();
        serve_read(1'b0);
        push(K_REQ, cyc + 3, 25'h0000080, 9'd1, 1'b0, 16'h1234);
        step(3);
        serve_write(1'b0);
        chk("both_busy_idle", busy, 0);

        // ack and next_req in the same cycle
        wr_addr = 25'h0000155;
        wr_data = 16'hA5A5;
        wr_req = 1'b1;
        push(K_REQ, cyc + 1, 25'h0000155, 9'd1, 1'b0, 16'hA5A5);
        step();
        serve_write(1'b1);
        chk("same_busy_idle", busy, 0);

        // continuous reads with a write pending
        rd_addr = 25'h0003000;
        wr_addr = 25'h0000100;
        wr_data = 16'hC0DE;
        rd_req = 1'b1;
        wr_req = 1'b1;
        push(K_REQ, cyc + 1, 25'h0003000, 9'd8, 1'b1);
        step();
        for (int k = 0; k < NRD; k++) begin
            serve_read(1'b1);
            if (k < NRD - 1) begin
                push(K_REQ, cyc + 1, 25'h0003000, 9'd8, 1'b1);
                step();
            end
        end
`ifndef ARB_WR_STARVE_GUARD_EN
        rd_req = 1'b0;
`endif
        push(K_REQ, cyc + 3, 25'h0000100, 9'd1, 1'b0, 16'hC0DE);
        step(3);
        serve_write(1'b1);
        rd_req = 1'b0;
        step(2);
        chk("starve_busy_idle", busy, 0);

        // reset in the middle of a read burst
        rd_addr = 25'h0004000;
        rd_req = 1'b1;
        push(K_REQ, cyc + 1, 25'h0004000, 9'd8, 1'b1);
        step();
        push(K_RDACK, cyc + 1);
        app_req_ack = 1'b1;
        step();
        app_req_ack = 1'b0;
        rd_req = 1'b0;
        app_rd_valid = 1'b1;
        step(2);
        chk("mid_busy", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid_app_req", app_req, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_rd_done", rd_done, 0);
        app_last_rd = 1'b1;
        step(2);
        chk("stray_busy", busy, 0);
        app_rd_valid = 1'b0;
        app_last_rd = 1'b0;
        step(3);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
